// File: rtl/poly_mult_seq_pkg.sv
// Shared state encoding and bus widths for the poly_mult load/readout sequencer.
// The widths must track the poly_mult core and its mem_dual RAMs.
package poly_mult_seq_pkg;

  localparam int PM_ADDR_WIDTH = 10;
  localparam int PM_LOGW       = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_POS = 3'd1,
    S_LOAD_RND = 3'd2,
    S_START    = 3'd3,
    S_WAIT     = 3'd4,
    S_READ     = 3'd5,
    S_DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/poly_mult_seq_rd_out_reg.sv
// Single-entry result register: tracks the one read in flight to the core RAM
// and presents the returned word on a ready/valid stream until it is taken.
module poly_mult_seq_rd_out_reg #(
  parameter int RD_LAT = 1,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_i,
  input  logic [DW-1:0] rd_data_i,
  input  logic          m_ready_i,
  output logic          can_issue_o,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o
);

  logic [RD_LAT:1] vld_pipe_q;
  logic            hold_q, hold_d;
  logic [DW-1:0]   data_q, data_d;
  logic            arrive, pending;

  assign arrive  = vld_pipe_q[RD_LAT];
  assign pending = |vld_pipe_q;

  // The word is shown straight from the RAM on its arrival cycle, then from data_q.
  assign m_valid_o   = arrive | hold_q;
  assign m_data_o    = arrive ? rd_data_i : data_q;
  assign can_issue_o = ~pending & (~m_valid_o | m_ready_i);

  always_comb begin
    hold_d = (arrive | hold_q) & ~m_ready_i;
    data_d = arrive ? rd_data_i : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      hold_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      vld_pipe_q[1] <= issue_i;
      for (int k = 2; k <= RD_LAT; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
      hold_q <= hold_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/poly_mult_seq.sv
// Load / start / readout sequencer for the sparse polynomial multiplier core.
// Streams positions and random words into the RAMs, kicks the core, drains results.
module poly_mult_seq
  import poly_mult_seq_pkg::*;
#(
  parameter int WEIGHT    = 66,
  parameter int N         = 17669,
  parameter int RND_WORDS = 553,
  parameter int RES_WORDS = 553,
  parameter int RD_LAT    = 1,
  parameter int TIMEOUT   = 1 << 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [31:0]              s_data,
  output logic                     pos_we,
  output logic [PM_ADDR_WIDTH-1:0] pos_addr,
  output logic [PM_LOGW-1:0]       pos_data,
  output logic                     rnd_we,
  output logic [PM_ADDR_WIDTH-1:0] rnd_addr,
  output logic [31:0]              rnd_data,
  output logic                     core_start,
  input  logic                     core_valid,
  output logic                     res_rd,
  output logic [PM_ADDR_WIDTH-1:0] res_addr,
  input  logic [31:0]              res_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [31:0]              m_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int AW  = PM_ADDR_WIDTH;
  localparam int LW  = PM_LOGW;
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [AW-1:0]  POS_LAST = AW'(WEIGHT - 1);
  localparam logic [AW-1:0]  RND_LAST = AW'(RND_WORDS - 1);
  localparam logic [AW-1:0]  RES_LAST = AW'(RES_WORDS - 1);
  localparam logic [AW-1:0]  RES_CNT  = AW'(RES_WORDS);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [AW-1:0]  ld_cnt_q, ld_cnt_d;
  logic [AW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]  hs_cnt_q, hs_cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;

  logic           pos_we_q, rnd_we_q, core_start_q;
  logic [AW-1:0]  pos_addr_q, rnd_addr_q;
  logic [LW-1:0]  pos_data_q;
  logic [31:0]    rnd_data_q;

  logic beat, bad_pos, can_issue, issue, hs;

  assign s_ready = (state_q == S_LOAD_POS) || (state_q == S_LOAD_RND);
  assign beat    = s_valid & s_ready;
  assign bad_pos = (32'(s_data[LW-1:0]) >= 32'(N)) || (|s_data[31:LW]);
  assign issue   = (state_q == S_READ) && (rd_cnt_q < RES_CNT) && can_issue;
  assign hs      = m_valid & m_ready;

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    rd_cnt_d = rd_cnt_q;
    hs_cnt_d = hs_cnt_q;
    wd_d     = wd_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        ld_cnt_d = '0;
        rd_cnt_d = '0;
        hs_cnt_d = '0;
        if (cmd_start) begin
          err_d   = 1'b0;
          state_d = S_LOAD_POS;
        end
      end
      S_LOAD_POS: if (beat) begin
        // Out-of-range positions are still written; the host learns via err.
        if (bad_pos) err_d = 1'b1;
        if (ld_cnt_q == POS_LAST) begin
          ld_cnt_d = '0;
          state_d  = S_LOAD_RND;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      S_LOAD_RND: if (beat) begin
        if (ld_cnt_q == RND_LAST) state_d = S_START;
        else                      ld_cnt_d = ld_cnt_q + 1'b1;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_valid) begin
          state_d = S_READ;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_READ: begin
        if (issue) rd_cnt_d = rd_cnt_q + 1'b1;
        if (hs) begin
          hs_cnt_d = hs_cnt_q + 1'b1;
          if (hs_cnt_q == RES_LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ld_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      hs_cnt_q     <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
      pos_we_q     <= 1'b0;
      pos_addr_q   <= '0;
      pos_data_q   <= '0;
      rnd_we_q     <= 1'b0;
      rnd_addr_q   <= '0;
      rnd_data_q   <= '0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      hs_cnt_q     <= hs_cnt_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      pos_we_q     <= beat && (state_q == S_LOAD_POS);
      rnd_we_q     <= beat && (state_q == S_LOAD_RND);
      core_start_q <= (state_q == S_START);
      if (beat && state_q == S_LOAD_POS) begin
        pos_addr_q <= ld_cnt_q;
        pos_data_q <= s_data[LW-1:0];
      end
      if (beat && state_q == S_LOAD_RND) begin
        rnd_addr_q <= ld_cnt_q;
        rnd_data_q <= s_data;
      end
    end
  end

  poly_mult_seq_rd_out_reg #(.RD_LAT(RD_LAT), .DW(32)) u_rd_out (
    .clk         (clk),
    .rst         (rst),
    .issue_i     (issue),
    .rd_data_i   (res_data),
    .m_ready_i   (m_ready),
    .can_issue_o (can_issue),
    .m_valid_o   (m_valid),
    .m_data_o    (m_data)
  );

  assign pos_we     = pos_we_q;
  assign pos_addr   = pos_addr_q;
  assign pos_data   = pos_data_q;
  assign rnd_we     = rnd_we_q;
  assign rnd_addr   = rnd_addr_q;
  assign rnd_data   = rnd_data_q;
  assign core_start = core_start_q;
  assign res_rd     = issue;
  assign res_addr   = issue ? rd_cnt_q : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_poly_mult_seq.sv
// Bench for poly_mult_seq: scenario tasks drive jobs against a small result-RAM
// model and compare every RAM write, strobe and result word against expectations.
module tb_poly_mult_seq;
  import poly_mult_seq_pkg::*;

  localparam int WEIGHT = 4;
  localparam int RNDW   = 6;
  localparam int RESW   = 6;
  localparam int TMO    = 64;
  localparam int NPOS   = 17669;
  localparam int AW     = PM_ADDR_WIDTH;
  localparam int LW     = PM_LOGW;

  logic clk = 1'b0, rst = 1'b1, cmd_start = 1'b0, s_valid = 1'b0;
  logic core_valid = 1'b0, m_ready = 1'b0;
  logic [31:0] s_data = '0, res_data = '0;
  logic s_ready, pos_we, rnd_we, core_start, res_rd, m_valid, busy, done, err;
  logic [AW-1:0] pos_addr, rnd_addr, res_addr;
  logic [LW-1:0] pos_data;
  logic [31:0]   rnd_data, m_data;

  int pass_cnt = 0, tot_cnt = 0;
  int n_cstart = 0, n_rd = 0, n_done = 0, n_pwe = 0, n_rwe = 0;
  logic [AW-1:0] pa_q[$], ra_q[$];
  logic [LW-1:0] pd_q[$];
  logic [31:0]   rd_q[$], got_q[$];
  logic [31:0]   pos_v[WEIGHT];
  logic [31:0]   rnd_v[RNDW];

  always #5 clk = ~clk;

  poly_mult_seq #(.WEIGHT(WEIGHT), .N(NPOS), .RND_WORDS(RNDW), .RES_WORDS(RESW),
                  .RD_LAT(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pos_we(pos_we), .pos_addr(pos_addr), .pos_data(pos_data),
    .rnd_we(rnd_we), .rnd_addr(rnd_addr), .rnd_data(rnd_data),
    .core_start(core_start), .core_valid(core_valid),
    .res_rd(res_rd), .res_addr(res_addr), .res_data(res_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .err(err)
  );

  // Core result RAM: synchronous read, one cycle latency.
  always @(posedge clk) if (res_rd) res_data <= 32'hA000 + 32'(res_addr);

  always @(negedge clk) begin
    if (core_start) n_cstart++;
    if (res_rd) n_rd++;
    if (done) n_done++;
    if (pos_we) begin n_pwe++; pa_q.push_back(pos_addr); pd_q.push_back(pos_data); end
    if (rnd_we) begin n_rwe++; ra_q.push_back(rnd_addr); rd_q.push_back(rnd_data); end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    tot_cnt++;
    if ({s_ready, pos_we, pos_addr, pos_data, rnd_we, rnd_addr, rnd_data, core_start,
         res_rd, res_addr, m_valid, m_data, busy, done, err} !== '0)
      $display("FAIL %s: outputs s_ready=%b pos_we=%b rnd_we=%b cs=%b rd=%b mv=%b md=%h busy=%b done=%b err=%b addr=%h/%h/%h want all 0",
               name, s_ready, pos_we, rnd_we, core_start, res_rd, m_valid, m_data, busy, done, err,
               pos_addr, rnd_addr, res_addr);
    else pass_cnt++;
  endtask

  task automatic load_job(input bit gapped);
    cmd_start = 1'b1; tick; cmd_start = 1'b0;
    tot_cnt++;
    if (s_ready !== 1'b1 || busy !== 1'b1 || err !== 1'b0)
      $display("FAIL start_ack: s_ready=%b busy=%b err=%b want 1 1 0", s_ready, busy, err);
    else pass_cnt++;
    for (int i = 0; i < WEIGHT + RNDW; i++) begin
      if (gapped && i > 0) begin s_valid = 1'b0; s_data = $urandom; tick; end
      s_valid = 1'b1;
      if (i < WEIGHT) s_data = pos_v[i];
      else            s_data = rnd_v[i-WEIGHT];
      tick;
    end
    s_valid = 1'b0;
    tot_cnt++;
    if (core_start !== 1'b0) $display("FAIL core_start_early: got %b want 0", core_start);
    else pass_cnt++;
    tick;
    tot_cnt++;
    if (core_start !== 1'b1 || busy !== 1'b1)
      $display("FAIL core_start_pulse: core_start=%b busy=%b want 1 1", core_start, busy);
    else pass_cnt++;
  endtask

  task automatic run_job(input bit gapped, input int wait_cyc, input int stall_word,
                         input int stall_len, input bit poke, input int stop_at);
    int hs, stall, last, bad_hold, bad_rd, bad_gap, c0, r0, d0;
    logic [31:0] held;
    logic exp_err;
    exp_err = 1'b0;
    for (int i = 0; i < WEIGHT; i++) if (pos_v[i] >= 32'(NPOS)) exp_err = 1'b1;
    pa_q.delete(); pd_q.delete(); ra_q.delete(); rd_q.delete(); got_q.delete();
    c0 = n_cstart; r0 = n_rd; d0 = n_done;
    held = '0;
    load_job(gapped);
    for (int k = 0; k < wait_cyc; k++) begin cmd_start = poke && (k == 0); tick; end
    cmd_start = 1'b0;
    core_valid = 1'b1; tick; core_valid = 1'b0;
    tot_cnt++;
    if (res_rd !== 1'b1 || res_addr !== '0)
      $display("FAIL first_rd: res_rd=%b res_addr=%0d want 1 0", res_rd, res_addr);
    else pass_cnt++;
    tick;
    tot_cnt++;
    if (m_valid !== 1'b1 || m_data !== 32'hA000)
      $display("FAIL first_out: m_valid=%b m_data=%h want 1 0000a000", m_valid, m_data);
    else pass_cnt++;
    hs = 0; stall = 0; last = -1; bad_hold = 0; bad_rd = 0; bad_gap = 0;
    for (int cyc = 0; cyc < 200 && hs < stop_at; cyc++) begin
      cmd_start = poke && (cyc == 1);
      m_ready = !(hs == stall_word && stall < stall_len);
      #1;
      if (m_valid && !m_ready) begin
        stall++;
        if (stall == 1) held = m_data;
        else if (m_data !== held) bad_hold++;
        if (res_rd) bad_rd++;
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        if (last >= 0 && cyc - last != 2) bad_gap++;
        last = cyc;
        hs++;
      end
      tick;
    end
    cmd_start = 1'b0; m_ready = 1'b0;
    if (stop_at < RESW) return;
    tot_cnt++;
    if (hs != RESW || done !== 1'b1)
      $display("FAIL done_pulse: handshakes=%0d done=%b want %0d 1", hs, done, RESW);
    else pass_cnt++;
    tick;
    tot_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_done: busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    for (int i = 0; i < WEIGHT; i++) begin
      tot_cnt++;
      if (i >= pa_q.size() || pa_q[i] !== AW'(i) || pd_q[i] !== pos_v[i][LW-1:0])
        $display("FAIL pos_write[%0d]: got %0d writes, want addr %0d data %h", i, pa_q.size(), i, pos_v[i][LW-1:0]);
      else pass_cnt++;
    end
    for (int i = 0; i < RNDW; i++) begin
      tot_cnt++;
      if (i >= ra_q.size() || ra_q[i] !== AW'(i) || rd_q[i] !== rnd_v[i])
        $display("FAIL rnd_write[%0d]: got %0d writes, want addr %0d data %h", i, ra_q.size(), i, rnd_v[i]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (pa_q.size() != WEIGHT || ra_q.size() != RNDW)
      $display("FAIL write_count: pos=%0d rnd=%0d want %0d %0d", pa_q.size(), ra_q.size(), WEIGHT, RNDW);
    else pass_cnt++;
    for (int i = 0; i < RESW; i++) begin
      tot_cnt++;
      if (i >= got_q.size() || got_q[i] !== 32'hA000 + 32'(i))
        $display("FAIL result[%0d]: got %0d words, want %h", i, got_q.size(), 32'hA000 + 32'(i));
      else pass_cnt++;
    end
    tot_cnt++;
    if (n_cstart - c0 != 1 || n_rd - r0 != RESW || n_done - d0 != 1)
      $display("FAIL strobe_count: core_start=%0d res_rd=%0d done=%0d want 1 %0d 1",
               n_cstart - c0, n_rd - r0, n_done - d0, RESW);
    else pass_cnt++;
    tot_cnt++;
    if (err !== exp_err) $display("FAIL err_flag: got %b want %b", err, exp_err);
    else pass_cnt++;
    tot_cnt++;
    if (stall_len > 0) begin
      if (bad_hold != 0 || bad_rd != 0 || stall != stall_len)
        $display("FAIL backpressure: unstable=%0d rd_during_stall=%0d stall=%0d want 0 0 %0d",
                 bad_hold, bad_rd, stall, stall_len);
      else pass_cnt++;
    end else begin
      if (bad_gap != 0) $display("FAIL throughput: %0d gaps not 2 cycles, want 0", bad_gap);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick;
    check_all_zero("reset_outputs");
    rst = 1'b0; tick;
    check_all_zero("idle_outputs");
  endtask

  task automatic test_ignored_idle;
    int p0, r0, d0;
    p0 = n_pwe + n_rwe; r0 = n_rd; d0 = n_done;
    s_valid = 1'b1; core_valid = 1'b1; s_data = 32'd5;
    tick; tick; tick;
    tot_cnt++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || n_pwe + n_rwe != p0 || n_rd != r0 || n_done != d0)
      $display("FAIL idle_ignore: s_ready=%b busy=%b writes=%0d reads=%0d want 0 0 0 0",
               s_ready, busy, n_pwe + n_rwe - p0, n_rd - r0);
    else pass_cnt++;
    s_valid = 1'b0; core_valid = 1'b0; tick;
  endtask

  task automatic test_nominal;
    pos_v[0] = 32'd3; pos_v[1] = 32'd7; pos_v[2] = 32'd100; pos_v[3] = 32'd17668;
    for (int i = 0; i < RNDW; i++) rnd_v[i] = $urandom;
    run_job(1'b0, 3, -1, 0, 1'b0, RESW);
  endtask

  task automatic test_bad_pos;
    pos_v[0] = 32'd3; pos_v[1] = 32'd17669; pos_v[2] = 32'd100; pos_v[3] = 32'd0;
    for (int i = 0; i < RNDW; i++) rnd_v[i] = $urandom;
    run_job(1'b0, 2, -1, 0, 1'b0, RESW);
    tick; tick;
    tot_cnt++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else pass_cnt++;
    pos_v[1] = 32'd17668;
    run_job(1'b0, 1, -1, 0, 1'b0, RESW);
  endtask

  task automatic test_timeout;
    int r0, d0;
    pos_v[0] = 32'd1; pos_v[1] = 32'd2; pos_v[2] = 32'd4; pos_v[3] = 32'd8;
    for (int i = 0; i < RNDW; i++) rnd_v[i] = $urandom;
    r0 = n_rd; d0 = n_done;
    load_job(1'b0);
    for (int k = 0; k < TMO - 1; k++) tick;
    tot_cnt++;
    if (busy !== 1'b1 || err !== 1'b0)
      $display("FAIL timeout_early: busy=%b err=%b want 1 0", busy, err);
    else pass_cnt++;
    tick;
    tot_cnt++;
    if (busy !== 1'b0 || err !== 1'b1)
      $display("FAIL timeout_fire: busy=%b err=%b want 0 1", busy, err);
    else pass_cnt++;
    tick; tick; tick;
    tot_cnt++;
    if (err !== 1'b1 || n_rd != r0 || n_done != d0)
      $display("FAIL timeout_quiet: err=%b res_rd=%0d done=%0d want 1 0 0", err, n_rd - r0, n_done - d0);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    pos_v[0] = 32'd10; pos_v[1] = 32'd20; pos_v[2] = 32'd30; pos_v[3] = 32'd40;
    for (int i = 0; i < RNDW; i++) rnd_v[i] = $urandom;
    run_job(1'b0, 0, 2, 10, 1'b0, RESW);
  endtask

  task automatic test_gapped_ignored;
    for (int i = 0; i < WEIGHT; i++) pos_v[i] = $urandom_range(NPOS - 1, 0);
    for (int i = 0; i < RNDW; i++) rnd_v[i] = $urandom;
    run_job(1'b1, 4, -1, 0, 1'b1, RESW);
  endtask

  task automatic test_reset_mid_read;
    int p0, c0, r0, d0;
    for (int i = 0; i < WEIGHT; i++) pos_v[i] = $urandom_range(NPOS - 1, 0);
    for (int i = 0; i < RNDW; i++) rnd_v[i] = $urandom;
    run_job(1'b0, 2, -1, 0, 1'b0, 3);
    m_ready = 1'b1;
    rst = 1'b1; tick;
    check_all_zero("reset_mid_read");
    rst = 1'b0; m_ready = 1'b0;
    p0 = n_pwe + n_rwe; c0 = n_cstart; r0 = n_rd; d0 = n_done;
    for (int k = 0; k < 5; k++) tick;
    tot_cnt++;
    if (n_pwe + n_rwe != p0 || n_cstart != c0 || n_rd != r0 || n_done != d0 || busy !== 1'b0)
      $display("FAIL post_reset_quiet: writes=%0d starts=%0d reads=%0d done=%0d busy=%b want all 0",
               n_pwe + n_rwe - p0, n_cstart - c0, n_rd - r0, n_done - d0, busy);
    else pass_cnt++;
    run_job(1'b0, 1, -1, 0, 1'b0, RESW);
  endtask

  task automatic test_random;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < WEIGHT; i++) pos_v[i] = $urandom_range(NPOS - 1, 0);
      if (j == 1) pos_v[2] = 32'h0001_0005;
      if (j == 2) pos_v[3] = 32'(NPOS - 1);
      for (int i = 0; i < RNDW; i++) rnd_v[i] = $urandom;
      run_job(1'($urandom_range(1, 0)), $urandom_range(20, 0),
              $urandom_range(RESW - 1, 0), $urandom_range(5, 1), 1'b0, RESW);
    end
  endtask

  initial begin
    test_reset;
    test_ignored_idle;
    test_nominal;
    test_bad_pos;
    test_timeout;
    test_backpressure;
    test_gapped_ignored;
    test_reset_mid_read;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
